led_seq_ctrl: RTL

- Owns the 4-bit board LED bank and the "advance LEDs" push-button.
- Debounces the button and steps a one-hot LED pattern on each press, with auto-repeat while the button is held.
- Arbitrates LED ownership between this local sequencer and the Nios PIO through a req/grant handshake.
- Sits between the board pins and the Nios system top.

---
 rtl/led_seq_pkg.sv | 7 +
 rtl/btn_debounce.sv | 71 +++++++
 rtl/led_seq_ctrl.sv | 54 +++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer
package led_seq_pkg;
  typedef enum logic {LOCAL, PIO} owner_t;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  localparam int LED_RESET_PATTERN = 1;
  localparam int STEP_W = 8;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and auto-repeat an active-low button into step pulses
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic step
);
  logic [1:0] sync_q;
  logic pressed;
  deb_state_t state, state_d;
  logic [31:0] cnt, cnt_d, hold, hold_d, lim;
  logic rep, rep_d, step_d;
  assign pressed = sync_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state <= RELEASED;
      cnt <= '0;
      hold <= '0;
      rep <= 1'b0;
      step <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ~btn_in};
      state <= state_d;
      cnt <= cnt_d;
      hold <= hold_d;
      rep <= rep_d;
      step <= step_d;
    end
  end
  // The hold timer survives short release glitches so bounces cannot restart the repeat delay
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    hold_d = hold;
    rep_d = rep;
    step_d = 1'b0;
    lim = rep ? 32'(REPEAT_CYCLES - 1) : 32'(HOLD_CYCLES - 1);
    case (state)
      RELEASED: if (pressed) begin
        state_d = PRESS_WAIT;
        cnt_d = '0;
      end
      PRESS_WAIT: if (!pressed) state_d = RELEASED;
        else if (cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
          state_d = HELD;
          step_d = 1'b1;
          hold_d = '0;
          rep_d = 1'b0;
        end else cnt_d = cnt + 32'd1;
      HELD: if (!pressed) begin
        state_d = RELEASE_WAIT;
        cnt_d = '0;
      end else if (hold == lim) begin
        step_d = 1'b1;
        hold_d = '0;
        rep_d = 1'b1;
      end else hold_d = hold + 32'd1;
      RELEASE_WAIT: if (pressed) state_d = HELD;
        else if (cnt == 32'(DEBOUNCE_CYCLES - 1)) state_d = RELEASED;
        else cnt_d = cnt + 32'd1;
      default: state_d = RELEASED;
    endcase
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: button-stepped one-hot LED sequencer with Nios PIO ownership handshake
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LED_W = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic btn_in,
  input  logic pio_req,
  input  logic [LED_W-1:0] pio_leds,
  output logic pio_grant,
  output logic [LED_W-1:0] leds_out,
  output logic btn_event,
  output logic [STEP_W-1:0] step_count
);
  owner_t owner, owner_d;
  logic [LED_W-1:0] pattern, pattern_d, leds_d;
  logic step_local;
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_deb (
    .clk(clk_clk),
    .rst(reset_reset),
    .btn_in(btn_in),
    .step(btn_event)
  );
  // Steps follow the owner before the edge; the LED mux follows the owner after it
  always_comb begin
    owner_d = pio_req ? PIO : LOCAL;
    step_local = btn_event && owner == LOCAL;
    pattern_d = step_local ? {pattern[LED_W-2:0], pattern[LED_W-1]} : pattern;
    leds_d = owner_d == PIO ? pio_leds : pattern_d;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      owner <= LOCAL;
      pattern <= LED_W'(LED_RESET_PATTERN);
      leds_out <= LED_W'(LED_RESET_PATTERN);
      step_count <= '0;
    end else begin
      owner <= owner_d;
      pattern <= pattern_d;
      leds_out <= leds_d;
      step_count <= step_count + STEP_W'(step_local);
    end
  end
  assign pio_grant = owner == PIO;
endmodule
